// File: rtl/ex_wb_stage_pkg.sv
// Shared types and constants for the execute-to-writeback stage.
// Datapath widths, flag bit positions, condition codes, occupancy states,
// the buffered entry layout and the branch-condition decode helper.
package ex_wb_stage_pkg;

  localparam int DATA_W     = 16;
  localparam int FR_FLAG_W  = 4;
  localparam int REG_ADDR_W = 3;
  localparam int COND_W     = 3;

  // Flag register bit positions
  localparam int FR_C = 0;
  localparam int FR_Z = 1;
  localparam int FR_N = 2;
  localparam int FR_V = 3;

  // Branch condition codes
  localparam logic [COND_W-1:0] COND_AL = 3'd0;
  localparam logic [COND_W-1:0] COND_EQ = 3'd1;
  localparam logic [COND_W-1:0] COND_NE = 3'd2;
  localparam logic [COND_W-1:0] COND_MI = 3'd3;
  localparam logic [COND_W-1:0] COND_PL = 3'd4;
  localparam logic [COND_W-1:0] COND_CS = 3'd5;
  localparam logic [COND_W-1:0] COND_CC = 3'd6;
  localparam logic [COND_W-1:0] COND_VS = 3'd7;

  // Skid buffer occupancy
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // One buffered writeback entry
  typedef struct packed {
    logic [DATA_W-1:0]     y;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] rd;
  } wb_entry_t;

  // Evaluate a condition code against a flag vector
  function automatic logic cond_eval(input logic [COND_W-1:0]    cond,
                                     input logic [FR_FLAG_W-1:0] f);
    logic r;
    r = 1'b0;
    case (cond)
      COND_AL: r = 1'b1;
      COND_EQ: r = f[FR_Z];
      COND_NE: r = ~f[FR_Z];
      COND_MI: r = f[FR_N];
      COND_PL: r = ~f[FR_N];
      COND_CS: r = f[FR_C];
      COND_CC: r = ~f[FR_C];
      COND_VS: r = f[FR_V];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_wb_stage_if.sv
// Handshake bundle between the alu side, this stage and regfile writeback.
//
// Handshake: on each side a transfer happens in a cycle where both valid
// and ready are high at the rising edge. valid must not depend on ready;
// once valid is raised the payload is held until the transfer occurs.
// in_ready is a registered output. The head payload (out_*) stays stable
// while out_valid is high and out_ready is low.
interface ex_wb_stage_if;
  import ex_wb_stage_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_y;
  logic [FR_FLAG_W-1:0]  in_flags;
  logic                  in_flag_we;
  logic                  in_wb_en;
  logic [REG_ADDR_W-1:0] in_rd;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_y;
  logic                  out_wb_en;
  logic [REG_ADDR_W-1:0] out_rd;

  // Environment side: produces ops, consumes writeback
  modport master (
    output in_valid, in_y, in_flags, in_flag_we, in_wb_en, in_rd, out_ready,
    input  in_ready, out_valid, out_y, out_wb_en, out_rd
  );

  // Stage side
  modport slave (
    input  in_valid, in_y, in_flags, in_flag_we, in_wb_en, in_rd, out_ready,
    output in_ready, out_valid, out_y, out_wb_en, out_rd
  );

endinterface

// File: rtl/ex_wb_stage_skid_buf.sv
// ex_skid_buf: 2-entry valid/ready buffer holding {y, wb_en, rd}.
// head_q is always the oldest entry; tail_q is only meaningful when FULL.
// flush empties the buffer and discards any same-cycle push.
module ex_skid_buf
  import ex_wb_stage_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      in_valid,
  output logic      in_ready,
  input  wb_entry_t in_data,
  output logic      out_valid,
  input  logic      out_ready,
  output wb_entry_t out_data,
  output occ_e      occ
);

  occ_e      occ_q, occ_d;
  wb_entry_t head_q, head_d;
  wb_entry_t tail_q, tail_d;
  logic      in_ready_q, in_ready_d;
  logic      push, pop;

  assign out_valid = (occ_q != OCC_EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = head_q;
  assign occ       = occ_q;
  assign push      = in_valid & in_ready_q & ~flush;
  assign pop       = out_valid & out_ready;

  // Next occupancy, entry movement and registered ready
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (push) begin
            head_d = in_data;
            occ_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head_d = in_data;
          end else if (push) begin
            tail_d = in_data;
            occ_d  = OCC_FULL;
          end else if (pop) begin
            occ_d  = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // in_ready is low here, so only a pop can occur
          if (pop) begin
            head_d = tail_q;
            occ_d  = OCC_ONE;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
    in_ready_d = (occ_d != OCC_FULL);
  end

  // State and payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= OCC_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: execute-to-writeback stage. Buffers alu results in a
// 2-entry skid buffer, owns the flag register FR (updated on acceptance)
// and decodes branch conditions from it.
// Optional macro FR_BYPASS_EN: cond_true sees flags being accepted this
// cycle instead of waiting for FR to update.
module ex_wb_stage
  import ex_wb_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  ex_wb_stage_if.slave         bus,
  output logic [FR_FLAG_W-1:0] fr,
  input  logic [COND_W-1:0]    cond,
  output logic                 cond_true,
  output occ_e                 dbg_occ
);

  wb_entry_t            in_data, out_data;
  logic                 push;
  logic [FR_FLAG_W-1:0] fr_q, fr_d;
  logic [FR_FLAG_W-1:0] flags_eval;

  assign in_data = '{y: bus.in_y, wb_en: bus.in_wb_en, rd: bus.in_rd};
  assign push    = bus.in_valid & bus.in_ready & ~flush;

  ex_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_data),
    .occ       (dbg_occ)
  );

  assign bus.out_y     = out_data.y;
  assign bus.out_wb_en = out_data.wb_en;
  assign bus.out_rd    = out_data.rd;

  // FR takes new flags when a flag-writing op is accepted
  always_comb begin
    fr_d = fr_q;
    if (push && bus.in_flag_we) begin
      fr_d = bus.in_flags;
    end
  end

  // FR register
  always_ff @(posedge clk) begin
    if (rst) begin
      fr_q <= '0;
    end else begin
      fr_q <= fr_d;
    end
  end

  assign fr = fr_q;

`ifdef FR_BYPASS_EN
  // Condition source: flags being accepted now, otherwise FR
  always_comb begin
    flags_eval = fr_q;
    if (push && bus.in_flag_we) begin
      flags_eval = bus.in_flags;
    end
  end
`else
  // Condition source: FR only
  always_comb begin
    flags_eval = fr_q;
  end
`endif

  assign cond_true = cond_eval(cond, flags_eval);

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed bench for ex_wb_stage: reset, single op latency, flag update and
// condition decode, backpressure with FIFO ordering, flush, flag_we=0,
// and reset mid-stream.
module tb_ex_wb_stage;
  import ex_wb_stage_pkg::*;

`ifdef FR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic                 flush;
  logic [FR_FLAG_W-1:0] fr;
  logic [COND_W-1:0]    cond;
  logic                 cond_true;
  occ_e                 dbg_occ;

  int n_checks;
  int n_pass;
  logic [DATA_W-1:0] exp_q[$];

  ex_wb_stage_if bus ();

  ex_wb_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .fr        (fr),
    .cond      (cond),
    .cond_true (cond_true),
    .dbg_occ   (dbg_occ)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic v, input logic [DATA_W-1:0] y,
                          input logic [FR_FLAG_W-1:0] f, input logic fwe,
                          input logic wbe, input logic [REG_ADDR_W-1:0] rd);
    bus.in_valid   = v;
    bus.in_y       = y;
    bus.in_flags   = f;
    bus.in_flag_we = fwe;
    bus.in_wb_en   = wbe;
    bus.in_rd      = rd;
  endtask

  // Pop the scoreboard head and compare with the DUT head
  task automatic check_head(input string tag);
    logic [DATA_W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(bus.out_y), 32'(e));
    end
  endtask

  // cond code -> expected result with FR = 4'b1100 (V=1 N=1 Z=0 C=0)
  logic exp_c_tbl [8];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_c_tbl[0] = 1'b1; exp_c_tbl[1] = 1'b0; exp_c_tbl[2] = 1'b1; exp_c_tbl[3] = 1'b1;
    exp_c_tbl[4] = 1'b0; exp_c_tbl[5] = 1'b0; exp_c_tbl[6] = 1'b1; exp_c_tbl[7] = 1'b1;

    // Reset
    rst = 1'b1;
    flush = 1'b0;
    cond = 3'd1;
    bus.out_ready = 1'b0;
    drive_op(1'b0, '0, '0, 1'b0, 1'b0, '0);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_y",     32'(bus.out_y),     32'd0);
    check("rst_out_rd",    32'(bus.out_rd),    32'd0);
    check("rst_out_wb_en", 32'(bus.out_wb_en), 32'd0);
    check("rst_fr",        32'(fr),            32'd0);
    check("rst_occ",       32'(dbg_occ),       32'(OCC_EMPTY));
    check("rst_cond_eq",   32'(cond_true),     32'd0);

    // 1: single op, latency 1
    bus.out_ready = 1'b1;
    drive_op(1'b1, 16'h1234, 4'h0, 1'b0, 1'b1, 3'd3);
    tick();
    drive_op(1'b0, '0, '0, 1'b0, 1'b0, '0);
    #1;
    check("t1_out_valid", 32'(bus.out_valid), 32'd1);
    check("t1_out_y",     32'(bus.out_y),     32'h1234);
    check("t1_out_rd",    32'(bus.out_rd),    32'd3);
    check("t1_out_wb_en", 32'(bus.out_wb_en), 32'd1);
    tick();
    check("t1_drained", 32'(bus.out_valid), 32'd0);

    // 2: 0x7FFF+1 -> 0x8000, V=1 N=1, flag_we
    cond = 3'd7;
    drive_op(1'b1, 16'h8000, 4'b1100, 1'b1, 1'b1, 3'd1);
    #1;
    check("t2_vs_same_cycle", 32'(cond_true), 32'(BYP));
    tick();
    drive_op(1'b0, '0, '0, 1'b0, 1'b0, '0);
    #1;
    check("t2_fr", 32'(fr), 32'hC);
    for (int c = 0; c < 8; c++) begin
      cond = 3'(c);
      #1;
      check($sformatf("t2_cond%0d", c), 32'(cond_true), 32'(exp_c_tbl[c]));
    end
    tick();
    check("t2_drained", 32'(bus.out_valid), 32'd0);

    // 3/4: backpressure, FULL, FIFO order, push+pop at ONE
    bus.out_ready = 1'b0;
    drive_op(1'b1, 16'h000A, 4'h0, 1'b0, 1'b1, 3'd2);
    exp_q.push_back(16'h000A);
    tick();
    check("t3_occ_one", 32'(dbg_occ), 32'(OCC_ONE));
    check("t3_ready_one", 32'(bus.in_ready), 32'd1);
    drive_op(1'b1, 16'h000B, 4'h0, 1'b0, 1'b1, 3'd2);
    exp_q.push_back(16'h000B);
    tick();
    drive_op(1'b1, 16'h000C, 4'h0, 1'b0, 1'b1, 3'd2);
    exp_q.push_back(16'h000C);
    check("t3_ready_full", 32'(bus.in_ready), 32'd0);
    check("t3_occ_full",   32'(dbg_occ),      32'(OCC_FULL));
    tick();
    check("t3_hold_ready", 32'(bus.in_ready), 32'd0);
    check("t3_hold_head",  32'(bus.out_y),    32'h000A);
    bus.out_ready = 1'b1;
    #1;
    check_head("t3_pop_a");
    tick();
    check("t4_occ_one", 32'(dbg_occ), 32'(OCC_ONE));
    check("t4_ready",   32'(bus.in_ready), 32'd1);
    check_head("t3_pop_b");
    tick();
    drive_op(1'b0, '0, '0, 1'b0, 1'b0, '0);
    #1;
    check("t4_pushpop_one", 32'(dbg_occ), 32'(OCC_ONE));
    check_head("t3_pop_c");
    tick();
    check("t3_empty", 32'(bus.out_valid), 32'd0);
    check("t3_sb_left", 32'(exp_q.size()), 32'd0);

    // 5: push with flush -> dropped, FR unchanged
    cond = 3'd1;
    flush = 1'b1;
    drive_op(1'b1, 16'h0000, 4'b0010, 1'b1, 1'b1, 3'd4);
    #1;
    check("t5_eq_no_bypass", 32'(cond_true), 32'd0);
    tick();
    flush = 1'b0;
    drive_op(1'b0, '0, '0, 1'b0, 1'b0, '0);
    #1;
    check("t5_out_valid", 32'(bus.out_valid), 32'd0);
    check("t5_fr",        32'(fr),            32'hC);
    check("t5_in_ready",  32'(bus.in_ready),  32'd1);

    // 5b: flush a FULL buffer
    bus.out_ready = 1'b0;
    drive_op(1'b1, 16'h0D0D, 4'h0, 1'b0, 1'b1, 3'd5);
    tick();
    tick();
    drive_op(1'b0, '0, '0, 1'b0, 1'b0, '0);
    check("t5b_full", 32'(dbg_occ), 32'(OCC_FULL));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5b_flushed_valid", 32'(bus.out_valid), 32'd0);
    check("t5b_flushed_ready", 32'(bus.in_ready),  32'd1);

    // 6: flag_we=0 leaves FR; cond ALWAYS
    bus.out_ready = 1'b1;
    cond = 3'd0;
    drive_op(1'b1, 16'h5555, 4'hF, 1'b0, 1'b0, 3'd6);
    #1;
    check("t6_always", 32'(cond_true), 32'd1);
    tick();
    drive_op(1'b0, '0, '0, 1'b0, 1'b0, '0);
    #1;
    check("t6_fr",        32'(fr),            32'hC);
    check("t6_out_y",     32'(bus.out_y),     32'h5555);
    check("t6_out_wb_en", 32'(bus.out_wb_en), 32'd0);
    check("t6_out_rd",    32'(bus.out_rd),    32'd6);
    tick();

    // Reset mid-stream
    bus.out_ready = 1'b0;
    drive_op(1'b1, 16'h00EE, 4'h3, 1'b1, 1'b1, 3'd7);
    tick();
    drive_op(1'b0, '0, '0, 1'b0, 1'b0, '0);
    check("rs_fr_loaded", 32'(fr), 32'h3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_fr",        32'(fr),            32'd0);
    check("rs_out_valid", 32'(bus.out_valid), 32'd0);
    check("rs_in_ready",  32'(bus.in_ready),  32'd1);
    check("rs_out_y",     32'(bus.out_y),     32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
